// File: rtl/value_source.sv
// value_source
//   Byte FIFO feeding a processor input port, with a small sequencing FSM
//   that reports when a loaded sequence has been fully consumed.
//
//   Parameters
//     L_DEPTH    FIFO depth in bytes (power of two, 2..256)
//     L_TIMEOUT  DRAIN cycles without a successful pop before o_done is forced
//
//   Ports
//     i_clk          rising-edge clock
//     i_rst          synchronous active-low reset
//     i_load_value   byte to queue
//     i_load_wr      one-cycle load strobe
//     i_load_last    marks the loaded byte as the final one of a sequence
//     o_load_full    registered FIFO-full flag
//     o_value        head byte (8'h00 when empty)
//     o_value_valid  head byte present
//     i_value_rd     one-cycle read strobe, pops the head
//     o_count        occupancy, 0..L_DEPTH
//     o_done         one-cycle strobe when the sequence is complete
//     o_overflow     (only with VALUE_SOURCE_OVERFLOW_EN) sticky flag for a
//                    dropped load or an ignored read, cleared by reset
//
//   Build option: define VALUE_SOURCE_OVERFLOW_EN to add o_overflow.
module value_source #(
  parameter int L_DEPTH   = 16,
  parameter int L_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_load_value,
  input  logic       i_load_wr,
  input  logic       i_load_last,
  output logic       o_load_full,
  output logic [7:0] o_value,
  output logic       o_value_valid,
  input  logic       i_value_rd,
  output logic [8:0] o_count,
  output logic       o_done
`ifdef VALUE_SOURCE_OVERFLOW_EN
  ,
  output logic       o_overflow
`endif
);

  localparam int PW = (L_DEPTH > 1) ? $clog2(L_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [8:0]      r_mem [L_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [8:0]      r_count;
  logic            r_full;
  logic [15:0]     r_tcnt;
  logic [15:0]     w_tcnt_next;
  logic [15:0]     w_tcnt_inc;

  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [8:0]      w_head;
  logic [8:0]      w_count_next;

  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_value_rd & ~w_empty;
  // When full, a simultaneous pop frees the slot in the same cycle.
  assign w_push  = i_load_wr & (~r_full | w_pop);

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 9'd1;
      2'b01:   w_count_next = r_count - 9'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset: entries are only observable behind r_count.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_push) begin
      r_mem[r_wr_ptr] <= {i_load_last, i_load_value};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == 9'(L_DEPTH));
    end
  end

  assign w_tcnt_inc = r_tcnt + 16'd1;

  // DRAIN ends on the first cycle with no read strobe; the timeout covers a
  // processor that keeps strobing an empty FIFO.
  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_push) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_pop && w_head[8]) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_value_rd) begin
          w_state_next = S_DONE;
        end else if (!w_pop) begin
          w_tcnt_next = w_tcnt_inc;
          if (w_tcnt_inc >= 16'(L_TIMEOUT)) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_tcnt  <= w_tcnt_next;
    end
  end

`ifdef VALUE_SOURCE_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_overflow <= 1'b0;
    end else if ((i_load_wr && !w_push) || (i_value_rd && !w_pop)) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`endif

  assign o_load_full   = r_full;
  assign o_count       = r_count;
  assign o_value_valid = ~w_empty;
  assign o_value       = w_empty ? 8'h00 : w_head[7:0];
  assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_value_source.sv
module tb_value_source;

  localparam int DEPTH = 16;
  localparam int TMO   = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ld_val;
  logic       ld_wr;
  logic       ld_last;
  logic       rd;
  logic       load_full;
  logic [7:0] value;
  logic       value_valid;
  logic [8:0] count;
  logic       done;
  logic       ovf_obs;

  always #5 clk = ~clk;

  value_source #(
    .L_DEPTH   (DEPTH),
    .L_TIMEOUT (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_load_value  (ld_val),
    .i_load_wr     (ld_wr),
    .i_load_last   (ld_last),
    .o_load_full   (load_full),
    .o_value       (value),
    .o_value_valid (value_valid),
    .i_value_rd    (rd),
    .o_count       (count),
    .o_done        (done)
`ifdef VALUE_SOURCE_OVERFLOW_EN
    ,
    .o_overflow    (ovf_obs)
`endif
  );

`ifndef VALUE_SOURCE_OVERFLOW_EN
  assign ovf_obs = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: queue of {last, data}; phase names the sequencing stage.
  logic [8:0] m_q[$];
  string      m_phase = "idle";
  int         m_idle_rds = 0;
  bit         m_ovf = 0;

  function automatic void model_step(bit r, bit w, bit l, logic [7:0] v, bit rdv);
    bit pop, push, pop_last;
    if (!r) begin
      m_q.delete();
      m_phase = "idle";
      m_idle_rds = 0;
      m_ovf = 0;
      return;
    end
    pop      = rdv && (m_q.size() > 0);
    push     = w && ((m_q.size() < DEPTH) || pop);
    pop_last = pop && m_q[0][8];
    if ((w && !push) || (rdv && !pop)) m_ovf = 1;
    if (m_phase == "idle") begin
      if (push) m_phase = "stream";
    end else if (m_phase == "stream") begin
      if (pop_last) begin
        m_phase = "drain";
        m_idle_rds = 0;
      end
    end else if (m_phase == "drain") begin
      if (!rdv) m_phase = "done";
      else if (pop) m_idle_rds = 0;
      else begin
        m_idle_rds++;
        if (m_idle_rds >= TMO) m_phase = "done";
      end
    end else begin
      m_phase = "idle";
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({l, v});
  endfunction

  // {count, valid, value, full, done, overflow}
  function automatic logic [20:0] obs();
    return {count, value_valid, value, load_full, done, ovf_obs};
  endfunction

  function automatic logic [20:0] expv();
    logic [8:0] c;
    logic [7:0] hv;
    bit         e_ovf;
    c  = 9'(m_q.size());
    hv = (m_q.size() > 0) ? m_q[0][7:0] : 8'h00;
`ifdef VALUE_SOURCE_OVERFLOW_EN
    e_ovf = m_ovf;
`else
    e_ovf = 0;
`endif
    return {c, (m_q.size() > 0), hv, (m_q.size() == DEPTH), (m_phase == "done"), e_ovf};
  endfunction

  task automatic drive(input bit r, input bit w, input bit l, input logic [7:0] v, input bit rdv);
    rst_n = r; ld_wr = w; ld_last = l; ld_val = v; rd = rdv;
    @(posedge clk);
    model_step(r, w, l, v, rdv);
    #1;
    rst_n = 1'b1; ld_wr = 1'b0; ld_last = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 8'hAA, 1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL reset: got %h exp %h", obs(), expv());
      end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] seq [3];
    int pulses = 0;
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, (i == 2), seq[i], 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL seq_load: got %h exp %h", obs(), expv());
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (value !== seq[i]) begin
        n_bad++;
        $display("FAIL seq_head: got %h exp %h", value, seq[i]);
      end
      drive(1, 0, 0, 8'h00, 1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL seq_read: got %h exp %h", obs(), expv());
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'h00, 0);
      pulses += int'(done);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL seq_idle: got %h exp %h", obs(), expv());
      end
    end
    n_vec++;
    if (pulses != 1 || count !== 9'd0) begin
      n_bad++;
      $display("FAIL seq_done: got pulses=%0d count=%0d exp pulses=1 count=0", pulses, count);
    end
  endtask

  task automatic test_fill_overflow();
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 8'(i + 8'h40), 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL fill: got %h exp %h", obs(), expv());
      end
    end
    n_vec++;
    if (count !== 9'd16 || load_full !== 1'b1 || value !== 8'h40) begin
      n_bad++;
      $display("FAIL fill_full: got count=%0d full=%b head=%h exp 16 1 40", count, load_full, value);
    end
`ifdef VALUE_SOURCE_OVERFLOW_EN
    n_vec++;
    if (ovf_obs !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_ovf: got %b exp 1", ovf_obs);
    end
`endif
  endtask

  task automatic test_empty_read();
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8'h00, 1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL empty_rd: got %h exp %h", obs(), expv());
      end
    end
    n_vec++;
    if (value_valid !== 1'b0 || count !== 9'd0 || value !== 8'h00) begin
      n_bad++;
      $display("FAIL empty_state: got valid=%b count=%0d value=%h exp 0 0 00", value_valid, count, value);
    end
`ifdef VALUE_SOURCE_OVERFLOW_EN
    n_vec++;
    if (ovf_obs !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_ovf: got %b exp 1", ovf_obs);
    end
`endif
    // load and read together on empty: load only
    drive(1, 1, 0, 8'h9C, 1);
    n_vec++;
    if (obs() !== expv()) begin
      n_bad++;
      $display("FAIL empty_ldrd: got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 0, 8'($urandom), 1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL b2b: got %h exp %h", obs(), expv());
      end
    end
    n_vec++;
    if (count !== 9'd16 || load_full !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_count: got count=%0d full=%b exp 16 1", count, load_full);
    end
    // drain completely to confirm order across the wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 8'h00, 1);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL b2b_drain: got %h exp %h", obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, (i == 9), 8'(i * 7), 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 0);
    n_vec++;
    if (count !== 9'd0 || value_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: got count=%0d valid=%b done=%b exp 0 0 0", count, value_valid, done);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'h00, 0);
      pulses += int'(done);
    end
    n_vec++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL rst_mid_done: got %0d pulses exp 0", pulses);
    end
    // idle after reset: a first load starts a fresh sequence that completes
    drive(1, 1, 1, 8'hE1, 0);
    drive(1, 0, 0, 8'h00, 1);
    drive(1, 0, 0, 8'h00, 0);
    n_vec++;
    if (obs() !== expv()) begin
      n_bad++;
      $display("FAIL rst_mid_seq: got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first  = -1;
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 1, 1, 8'h77, 0);
    drive(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 8'h00, (i < 8));
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL timeout: got %h exp %h", obs(), expv());
      end
    end
    n_vec++;
    if (pulses != 1 || first < 0 || first >= TMO) begin
      n_bad++;
      $display("FAIL timeout_pulse: got pulses=%0d at=%0d exp 1 pulse before %0d", pulses, first, TMO);
    end
  endtask

  task automatic test_random();
    bit r, w, l, rv;
    drive(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      w  = ($urandom_range(0, 99) < 55);
      l  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 99) < 45);
      drive(r, w, l, 8'($urandom), rv);
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ld_wr = 1'b0; ld_last = 1'b0; ld_val = '0; rd = 1'b0;
    #2;
    test_reset();
    test_sequence();
    test_fill_overflow();
    test_empty_read();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/value_source.md
VALUE_SOURCE -- requirements
Module: value_source

Interface
REQ-001 Parameter L_DEPTH, default 16, FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter L_TIMEOUT, default 255, read-idle cycles in DRAIN before o_done is forced; 1..65535.
REQ-003 i_clk  input  1  single processor clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-low.
REQ-005 i_load_value  input  8  byte to queue, written by bench.
REQ-006 i_load_wr  input  1  one-cycle load strobe.
REQ-007 i_load_last  input  1  qualifies i_load_wr: byte is final of sequence.
REQ-008 o_load_full  output  1  FIFO full; load side must not strobe.
REQ-009 o_value  output  8  head byte presented to processor input port.
REQ-010 o_value_valid  output  1  head byte present.
REQ-011 i_value_rd  input  1  one-cycle processor read strobe; pops head.
REQ-012 o_count  output  9  current FIFO occupancy, 0..L_DEPTH.
REQ-013 o_done  output  1  one-cycle strobe when sequence complete.

Function
REQ-014 FIFO storage SHALL be L_DEPTH x 9 bits (8 data plus last flag); read/write pointers of log2(L_DEPTH) bits SHALL wrap modulo L_DEPTH.
REQ-015 o_value SHALL equal the head data combinationally from the registered read pointer; undefined data SHALL be driven 8'h00 when o_value_valid=0.
REQ-016 A load SHALL become visible on o_value_valid/o_count one cycle after the i_load_wr edge.
REQ-017 A read SHALL advance the head one cycle after the i_value_rd edge.
REQ-018 i_load_wr while full SHALL be dropped; FIFO contents and pointers unchanged.
REQ-019 i_value_rd while empty SHALL be ignored; o_value held 8'h00.
REQ-020 Simultaneous load and read when not empty and not full SHALL leave o_count unchanged.
REQ-021 Simultaneous load and read when full SHALL perform both (read frees slot in same cycle).
REQ-022 Simultaneous load and read when empty SHALL perform load only; read ignored.
REQ-023 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-024 IDLE -> STREAM on first accepted load.
REQ-025 STREAM -> DRAIN when the read pops an entry with last flag set.
REQ-026 DRAIN -> DONE when the next cycle has no read pending, or after L_TIMEOUT cycles without reads, whichever first.
REQ-027 o_done SHALL pulse high exactly one cycle on entry to DONE.
REQ-028 DONE -> IDLE on the cycle after o_done; FIFO contents retained.
REQ-029 Loads SHALL be accepted in all states; reads in DRAIN continue to pop normally.
REQ-030 o_load_full SHALL be registered and equal (o_count == L_DEPTH).

Reset
REQ-031 With i_rst=0 at a clock edge: pointers 0, o_count 0, o_value_valid 0, o_value 8'h00, o_load_full 0, o_done 0, FSM IDLE, timeout counter 0.
REQ-032 Reset mid-sequence SHALL discard all queued bytes; no o_done issued.
REQ-033 Loads and reads during reset SHALL be ignored.

Configuration
REQ-034 Macro VALUE_SOURCE_OVERFLOW_EN: when defined, adds output o_overflow (1 bit), a sticky flag set on any dropped load (REQ-018) or ignored read (REQ-019), cleared only by reset.
REQ-035 Without VALUE_SOURCE_OVERFLOW_EN, the port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 Load 8'h12, 8'h34, 8'h56 (last) then three reads -> o_value 12,34,56 in order, o_done one cycle after DRAIN exits, o_count returns 0.
REQ-037 Load 17 bytes into L_DEPTH=16 -> o_load_full=1 after 16th, 17th dropped, o_count=16; with macro, o_overflow=1.
REQ-038 Read on empty FIFO -> o_value_valid stays 0, o_count 0; with macro, o_overflow=1.
REQ-039 Fill to full, strobe load and read same cycle for 40 cycles -> o_count stays 16, data order preserved across pointer wrap.
REQ-040 Load 10 bytes, read 4, pull i_rst low one cycle -> o_count 0, o_value_valid 0, FSM IDLE, no o_done.
REQ-041 Last byte read, then no reads with L_TIMEOUT=5 -> o_done pulses within 5 cycles, single cycle wide.
